// File: rtl/mem_access.sv
// MEM stage: runs loads/stores as a req/ack bus transaction and passes other ops through.
// Latency: 0 cycles for non-memory ops; memory ops take request + wait + ack + DONE cycles (min 3).
// Backpressure: raises stallreq_o while an access is outstanding; dreq_o is held until dack_i or timeout.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        dreq_o,
  output logic        dwe_o,
  output logic [31:0] daddr_o,
  output logic [3:0]  dsel_o,
  output logic [31:0] ddata_o,
  input  logic        dack_i,
  input  logic [31:0] ddata_i,
  output logic        err_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
  localparam logic       TIMEOUT_EN  = (TIMEOUT != 0);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [31:0] lbuf;
  logic        aborted;

  logic        is_mem;
  logic        is_load;
  logic        is_signed;
  logic [1:0]  sz;
  logic        misal;
  logic [3:0]  sel_c;
  logic [31:0] sdata_c;
  logic [31:0] ldata_c;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  assign cnt_inc = cnt + 8'd1;

  // Decode the operation into access size, direction and sign handling.
  always_comb begin
    is_mem    = 1'b1;
    is_load   = 1'b0;
    is_signed = 1'b0;
    sz        = SZ_W;
    case (aluop_i)
      EXE_LB_OP:  begin is_load = 1'b1; is_signed = 1'b1; sz = SZ_B; end
      EXE_LH_OP:  begin is_load = 1'b1; is_signed = 1'b1; sz = SZ_H; end
      EXE_LW_OP:  begin is_load = 1'b1; sz = SZ_W; end
      EXE_LBU_OP: begin is_load = 1'b1; sz = SZ_B; end
      EXE_LHU_OP: begin is_load = 1'b1; sz = SZ_H; end
      EXE_SB_OP:  sz = SZ_B;
      EXE_SH_OP:  sz = SZ_H;
      EXE_SW_OP:  sz = SZ_W;
      default:    is_mem = 1'b0;
    endcase
  end

  // Alignment check, byte lanes and replicated store data for the request.
  always_comb begin
    misal   = 1'b0;
    sel_c   = 4'b1111;
    sdata_c = reg2_i;
    case (sz)
      SZ_B: begin
        sel_c   = 4'b0001 << addr_i[1:0];
        sdata_c = {4{reg2_i[7:0]}};
      end
      SZ_H: begin
        misal   = addr_i[0];
        sel_c   = addr_i[1] ? 4'b1100 : 4'b0011;
        sdata_c = {2{reg2_i[15:0]}};
      end
      default: misal = (addr_i[1:0] != 2'b00);
    endcase
  end

  // Pick the addressed lane out of the captured load word and extend it.
  always_comb begin
    case (addr_i[1:0])
      2'd0:    lbyte = lbuf[7:0];
      2'd1:    lbyte = lbuf[15:8];
      2'd2:    lbyte = lbuf[23:16];
      default: lbyte = lbuf[31:24];
    endcase
    lhalf = addr_i[1] ? lbuf[31:16] : lbuf[15:0];
    case (sz)
      SZ_B:    ldata_c = {{24{is_signed & lbyte[7]}}, lbyte};
      SZ_H:    ldata_c = {{16{is_signed & lhalf[15]}}, lhalf};
      default: ldata_c = lbuf;
    endcase
  end

  // Hold the pipeline from the request cycle until the access completes.
  always_comb begin
    stallreq_o = (state == BUSY) || ((state == IDLE) && is_mem && !misal);
  end

  // Writeback fields: pass-through, suppressed while a memory op is pending, load result in DONE.
  always_comb begin
    wd_o    = wd_i;
    wreg_o  = wreg_i;
    wdata_o = wdata_i;
    if (rst) begin
      wd_o    = 5'd0;
      wreg_o  = 1'b0;
      wdata_o = 32'd0;
    end else if (state == DONE) begin
      wreg_o  = is_load && !aborted;
      wdata_o = (is_load && !aborted) ? ldata_c : 32'd0;
    end else if (is_mem) begin
      wreg_o  = 1'b0;
      wdata_o = 32'd0;
    end
  end

  // Access sequencer: issue request, wait for ack or timeout, then one DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dreq_o  <= 1'b0;
      dwe_o   <= 1'b0;
      daddr_o <= 32'd0;
      dsel_o  <= 4'd0;
      ddata_o <= 32'd0;
      err_o   <= 1'b0;
      cnt     <= 8'd0;
      lbuf    <= 32'd0;
      aborted <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem) begin
            if (misal) begin
              err_o <= 1'b1;
            end else begin
              dreq_o  <= 1'b1;
              dwe_o   <= !is_load;
              daddr_o <= {addr_i[31:2], 2'b00};
              dsel_o  <= sel_c;
              ddata_o <= sdata_c;
              cnt     <= 8'd0;
              aborted <= 1'b0;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt_inc;
          if (dack_i) begin
            lbuf   <= ddata_i;
            dreq_o <= 1'b0;
            state  <= DONE;
          end else if (TIMEOUT_EN && (cnt_inc == TIMEOUT_CNT)) begin
            dreq_o  <= 1'b0;
            err_o   <= 1'b1;
            aborted <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus randomized loads/stores against an arithmetic model.
module tb_mem_access;

  localparam int unsigned TO = 4;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_ADD = 8'b0010_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        dreq_o;
  logic        dwe_o;
  logic [31:0] daddr_o;
  logic [3:0]  dsel_o;
  logic [31:0] ddata_o;
  logic        dack_i;
  logic [31:0] ddata_i;
  logic        err_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .addr_i(addr_i), .reg2_i(reg2_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o),
    .dreq_o(dreq_o), .dwe_o(dwe_o), .daddr_o(daddr_o), .dsel_o(dsel_o), .ddata_o(ddata_o),
    .dack_i(dack_i), .ddata_i(ddata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: access size in bytes, direction and signedness by opcode.
  function automatic int op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic bit op_signed(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  // Reference: shift the word down by the byte offset, mask to size, sign-extend arithmetically.
  function automatic logic [31:0] load_exp(input logic [7:0] op, input logic [31:0] word, input logic [31:0] addr);
    longint v;
    longint span;
    int sz;
    sz   = op_size(op);
    span = longint'(1) << (8 * sz);
    v    = (longint'(word) >> (8 * int'(addr[1:0]))) % span;
    if (op_signed(op) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic set_nop();
    aluop_i = OP_ADD;
    wd_i    = 5'($urandom);
    wreg_i  = 1'($urandom);
    wdata_i = $urandom;
    addr_i  = $urandom;
    reg2_i  = $urandom;
  endtask

  // One complete instruction through MEM, checked cycle by cycle against the model.
  task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic [31:0] ldata, input int waits, input bit ack_en);
    int          sz;
    bit          ld;
    bit          misal;
    int          busy_n;
    int          stalls;
    logic [31:0] exp_sel;
    logic [31:0] exp_dat;
    sz      = op_size(op);
    ld      = op_load(op);
    misal   = (addr % 32'(sz)) != 0;
    busy_n  = ack_en ? waits + 1 : int'(TO);
    stalls  = 0;
    exp_sel = ((32'd1 << sz) - 32'd1) << addr[1:0];
    exp_dat = (sz == 1) ? {24'd0, reg2[7:0]} * 32'h0101_0101 :
              (sz == 2) ? {16'd0, reg2[15:0]} * 32'h0001_0001 : reg2;

    tick();
    aluop_i = op; addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = ld; wdata_i = $urandom; dack_i = 1'b0;
    #1;
    chk("idle_wreg", 32'(wreg_o), 32'(0));
    chk("idle_stall", 32'(stallreq_o), 32'(!misal));
    chk("idle_dreq", 32'(dreq_o), 32'(0));
    stalls += 32'(stallreq_o);

    if (misal) begin
      tick();
      set_nop();
      #1;
      chk("misal_err", 32'(err_o), 32'(1));
      chk("misal_dreq", 32'(dreq_o), 32'(0));
      chk("misal_stall", 32'(stallreq_o), 32'(0));
      tick();
      chk("misal_err_pulse", 32'(err_o), 32'(0));
      return;
    end

    for (int k = 1; k <= busy_n; k++) begin
      tick();
      chk("busy_dreq", 32'(dreq_o), 32'(1));
      chk("busy_stall", 32'(stallreq_o), 32'(1));
      chk("busy_dwe", 32'(dwe_o), 32'(!ld));
      chk("busy_daddr", daddr_o, addr & ~32'd3);
      chk("busy_dsel", 32'(dsel_o), exp_sel);
      if (!ld) chk("busy_ddata", ddata_o, exp_dat);
      chk("busy_err", 32'(err_o), 32'(0));
      stalls += 32'(stallreq_o);
      if (ack_en && k == busy_n) begin
        dack_i = 1'b1; ddata_i = ldata;
      end else begin
        dack_i = 1'b0; ddata_i = $urandom;
      end
    end

    tick();
    dack_i = 1'b0;
    #1;
    chk("done_stall", 32'(stallreq_o), 32'(0));
    chk("done_dreq", 32'(dreq_o), 32'(0));
    chk("done_err", 32'(err_o), 32'(!ack_en));
    chk("done_wreg", 32'(wreg_o), 32'(ld && ack_en));
    chk("done_wd", 32'(wd_o), 32'(wd));
    if (ld && ack_en) chk("done_wdata", wdata_o, load_exp(op, ldata, addr));
    chk("stall_cycles", 32'(stalls), 32'(busy_n + 1));

    // Next instruction is a non-memory op; a stray ack must not start anything.
    tick();
    set_nop();
    dack_i = 1'b1;
    #1;
    chk("pass_wd", 32'(wd_o), 32'(wd_i));
    chk("pass_wreg", 32'(wreg_o), 32'(wreg_i));
    chk("pass_wdata", wdata_o, wdata_i);
    chk("pass_stall", 32'(stallreq_o), 32'(0));
    chk("pass_err", 32'(err_o), 32'(0));
    tick();
    dack_i = 1'b0;
    chk("stray_ack_dreq", 32'(dreq_o), 32'(0));
    chk("stray_ack_stall", 32'(stallreq_o), 32'(0));
  endtask

  initial begin
    rst = 1'b1; dack_i = 1'b0; ddata_i = 32'd0;
    aluop_i = OP_ADD; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h1234_5678; addr_i = 32'd0; reg2_i = 32'd0;
    tick();
    tick();
    chk("rst_wd", 32'(wd_o), 32'(0));
    chk("rst_wreg", 32'(wreg_o), 32'(0));
    chk("rst_wdata", wdata_o, 32'(0));
    chk("rst_dreq", 32'(dreq_o), 32'(0));
    chk("rst_dwe", 32'(dwe_o), 32'(0));
    chk("rst_daddr", daddr_o, 32'(0));
    chk("rst_dsel", 32'(dsel_o), 32'(0));
    chk("rst_ddata", ddata_o, 32'(0));
    chk("rst_err", 32'(err_o), 32'(0));
    rst = 1'b0;

    // Non-memory op passes straight through in the same cycle.
    aluop_i = OP_ADD; wdata_i = 32'h5; wd_i = 5'd3; wreg_i = 1'b1;
    #1;
    chk("add_wd", 32'(wd_o), 32'(3));
    chk("add_wreg", 32'(wreg_o), 32'(1));
    chk("add_wdata", wdata_o, 32'h5);
    chk("add_stall", 32'(stallreq_o), 32'(0));

    // Directed cases.
    access(OP_LW,  32'h100, 32'h0,         5'd4, 32'hDEAD_BEEF, 2, 1'b1);
    access(OP_LB,  32'h103, 32'h0,         5'd5, 32'h80FF_0000, 0, 1'b1);
    access(OP_LBU, 32'h103, 32'h0,         5'd5, 32'h80FF_0000, 0, 1'b1);
    access(OP_SH,  32'h202, 32'h1234_ABCD, 5'd0, 32'h0,         1, 1'b1);
    access(OP_LW,  32'h101, 32'h0,         5'd6, 32'h0,         0, 1'b1);
    access(OP_LH,  32'h102, 32'h0,         5'd0, 32'h8001_7FFF, 0, 1'b1);
    access(OP_LW,  32'h300, 32'h0,         5'd8, 32'h0,         0, 1'b0);
    access(OP_SB,  32'h301, 32'h0000_00A5, 5'd9, 32'h0,         0, 1'b0);

    // Reset while an access is outstanding.
    tick();
    aluop_i = OP_LW; addr_i = 32'h400; wd_i = 5'd1; wreg_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_nop();
    #1;
    chk("rst_busy_dreq", 32'(dreq_o), 32'(0));
    chk("rst_busy_err", 32'(err_o), 32'(0));
    chk("rst_busy_idle", 32'(stallreq_o), 32'(0));

    // Randomized accesses.
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int          s;
      op = ops[$urandom_range(0, 7)];
      s  = op_size(op);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(s - 1);
      access(op, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 7) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
